// File: rtl/fetch_decode_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_decode_queue_if
//   Handshake bundle between fetch, the fetch/decode queue and decode.
//   Optional build macro used by the queue: FETCH_QUEUE_BYPASS_EN.
//
//   Parameters
//     IW     instruction word width
//     AW     pc width
//     DEPTH  queue entries; sets the width of count
//
//   Signals (direction as seen by the queue, modport slave)
//     in_valid         in   fetch presents a word
//     in_ready         out  queue accepts a word this cycle
//     in_instruction   in   fetched word
//     in_pc            in   pc of the fetched word
//     flush            in   pc changing, discard all contents
//     out_valid        out  head entry is valid
//     out_ready        in   decode consumes the head
//     out_instruction  out  head word
//     out_pc           out  head pc
//     out_has_flushed  out  head is the first entry accepted after a flush
//     count            out  occupancy
//
//   Modports
//     slave   the queue itself
//     master  the fetch/decode environment driving the queue
// ----------------------------------------------------------------------------
interface fetch_decode_queue_if #(
    parameter int unsigned IW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instruction;
    logic [AW-1:0] in_pc;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instruction;
    logic [AW-1:0] out_pc;
    logic          out_has_flushed;
    logic [CW-1:0] count;

    modport slave (
        input  in_valid,
        input  in_instruction,
        input  in_pc,
        input  flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instruction,
        output out_pc,
        output out_has_flushed,
        output count
    );

    modport master (
        output in_valid,
        output in_instruction,
        output in_pc,
        output flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instruction,
        input  out_pc,
        input  out_has_flushed,
        input  count
    );

endinterface

// File: rtl/fetch_decode_queue.sv
// ----------------------------------------------------------------------------
// fetch_decode_queue
//   Parametrised instruction buffer between fetch and decode. Holds up to
//   DEPTH {instruction, pc} pairs in a circular buffer so fetch can keep
//   running while decode stalls. A flush discards the contents in a single
//   cycle and the first entry accepted afterwards is tagged so decode can
//   see the redirect boundary (out_has_flushed).
//
//   Optional build macro: FETCH_QUEUE_BYPASS_EN
//     defined   : an empty queue presents in_* on out_* combinationally; if
//                 decode also takes it, nothing is written (latency 0).
//     undefined : no combinational in->out path; latency is at least 1.
//
//   Parameters
//     IW     instruction word width
//     AW     pc width
//     DEPTH  number of entries, >= 2, need not be a power of two
//
//   Ports
//     clock  single clock, all state updates on posedge
//     reset  synchronous, active-high
//     bus    fetch_decode_queue_if.slave: in_* handshake from fetch, out_*
//            handshake to decode, flush, and occupancy count
// ----------------------------------------------------------------------------
module fetch_decode_queue #(
    parameter int unsigned IW    = 32,
    parameter int unsigned AW    = 32,
    parameter int unsigned DEPTH = 4
) (
    input logic                 clock,
    input logic                 reset,
    fetch_decode_queue_if.slave bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    // Tag travels with the entry so it is reported exactly when that entry
    // reaches the head, independent of how long it waited.
    typedef struct packed {
        logic          tag;
        logic [AW-1:0] pc;
        logic [IW-1:0] instruction;
    } entry_t;

    entry_t        mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          flushed_pending_q, flushed_pending_d;

    logic          full;
    logic          empty;
    logic          push;      // handshake accepted on the input side
    logic          pop;       // head entry taken out of storage
    logic          write_en;  // accepted word actually stored
    entry_t        head;
    entry_t        wr_entry;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic          bypass_active;  // empty queue showing the input as head
    logic          bypass_fire;    // that word is consumed without storage
`endif

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    // ------------------------------------------------------------------------
    // Handshake and output decode
    // ------------------------------------------------------------------------
    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        head     = mem_q[rd_ptr_q];

        // No write-through when full, even with a same-cycle pop: in_ready
        // depends on registered state only (plus reset/flush).
        bus.in_ready = !reset && !bus.flush && !full;
        push         = bus.in_valid && bus.in_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
        bypass_active = !reset && !bus.flush && empty && bus.in_valid;
        bypass_fire   = bypass_active && bus.out_ready;

        bus.out_valid = !reset && (!empty || bypass_active);
        if (bypass_active) begin
            bus.out_instruction = bus.in_instruction;
            bus.out_pc          = bus.in_pc;
            bus.out_has_flushed = flushed_pending_q;
        end else begin
            bus.out_instruction = head.instruction;
            bus.out_pc          = head.pc;
            bus.out_has_flushed = head.tag && bus.out_valid;
        end
        write_en = push && !bypass_fire;
`else
        bus.out_valid       = !reset && !empty;
        bus.out_instruction = head.instruction;
        bus.out_pc          = head.pc;
        bus.out_has_flushed = head.tag && bus.out_valid;
        write_en            = push;
`endif

        // Only stored entries are popped; flush overrides any consumption.
        pop = bus.out_valid && bus.out_ready && !empty && !bus.flush;

        bus.count = count_q;

        wr_entry.tag         = flushed_pending_q;
        wr_entry.pc          = bus.in_pc;
        wr_entry.instruction = bus.in_instruction;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d          = wr_ptr_q;
        rd_ptr_d          = rd_ptr_q;
        count_d           = count_q;
        flushed_pending_d = flushed_pending_q;

        if (bus.flush) begin
            // Flush beats push and pop; same-cycle input is dropped.
            wr_ptr_d          = '0;
            rd_ptr_d          = '0;
            count_d           = '0;
            flushed_pending_d = 1'b1;
        end else begin
            if (write_en) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({write_en, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            // A bypassed word counts as accepted, so it consumes the tag too.
            if (push) begin
                flushed_pending_d = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers (synchronous reset wins over flush)
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q          <= '0;
            rd_ptr_q          <= '0;
            count_q           <= '0;
            flushed_pending_q <= 1'b0;
        end else begin
            wr_ptr_q          <= wr_ptr_d;
            rd_ptr_q          <= rd_ptr_d;
            count_q           <= count_d;
            flushed_pending_q <= flushed_pending_d;
        end
    end

    // Storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_decode_queue_if #(.IW(32), .AW(32), .DEPTH(4)) b4 ();
    fetch_decode_queue_if #(.IW(32), .AW(32), .DEPTH(3)) b3 ();

    fetch_decode_queue #(.IW(32), .AW(32), .DEPTH(4)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (b4.slave)
    );

    fetch_decode_queue #(.IW(32), .AW(32), .DEPTH(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (b3.slave)
    );

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
        logic        tag;
    } exp_t;

    exp_t sb4[$];
    exp_t sb3[$];
    logic fp4;
    logic fp3;
    int   checks;
    int   failures;

`ifdef FETCH_QUEUE_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample both queues at negedge: record accepted words, compare consumed heads.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (!reset && !b4.flush) begin
            if (b4.in_valid && b4.in_ready) begin
                e.instruction = b4.in_instruction;
                e.pc          = b4.in_pc;
                e.tag         = fp4;
                fp4           = 1'b0;
                sb4.push_back(e);
            end
            if (b4.out_valid && b4.out_ready) begin
                check("d4_output_expected", 64'(sb4.size() != 0), 64'd1);
                if (sb4.size() != 0) begin
                    e = sb4.pop_front();
                    check("d4_instruction", b4.out_instruction, e.instruction);
                    check("d4_pc", b4.out_pc, e.pc);
                    check("d4_has_flushed", b4.out_has_flushed, e.tag);
                end
            end
        end
        if (!reset && !b3.flush) begin
            if (b3.in_valid && b3.in_ready) begin
                e.instruction = b3.in_instruction;
                e.pc          = b3.in_pc;
                e.tag         = fp3;
                fp3           = 1'b0;
                sb3.push_back(e);
            end
            if (b3.out_valid && b3.out_ready) begin
                check("d3_output_expected", 64'(sb3.size() != 0), 64'd1);
                if (sb3.size() != 0) begin
                    e = sb3.pop_front();
                    check("d3_instruction", b3.out_instruction, e.instruction);
                    check("d3_pc", b3.out_pc, e.pc);
                    check("d3_has_flushed", b3.out_has_flushed, e.tag);
                end
            end
        end
        if (reset) begin
            sb4.delete();
            sb3.delete();
            fp4 = 1'b0;
            fp3 = 1'b0;
        end else begin
            if (b4.flush) begin
                sb4.delete();
                fp4 = 1'b1;
            end
            if (b3.flush) begin
                sb3.delete();
                fp3 = 1'b1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive4(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        b4.in_valid       = v;
        b4.in_instruction = instr;
        b4.in_pc          = pc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        fp4      = 1'b0;
        fp3      = 1'b0;
        drive4(1'b0, 32'h0, 32'h0);
        b4.flush     = 1'b0;
        b4.out_ready = 1'b0;
        b3.in_valid  = 1'b0;
        b3.in_instruction = 32'h0;
        b3.in_pc     = 32'h0;
        b3.flush     = 1'b0;
        b3.out_ready = 1'b0;

        // 1: reset held two cycles, then released
        reset = 1'b1;
        tick();
        check("rst_in_ready_low", b4.in_ready, 0);
        check("rst_out_valid_low", b4.out_valid, 0);
        tick();
        reset = 1'b0;
        #1;
        check("rst_count", b4.count, 0);
        check("rst_out_valid", b4.out_valid, 0);
        check("rst_in_ready", b4.in_ready, 1);
        check("rst_has_flushed", b4.out_has_flushed, 0);

        // 2: two pushes with decode stalled, then drain in order
        drive4(1'b1, 32'h11111111, 32'h100);
        #1;
        check("latency_first_push", b4.out_valid, BYP);
        tick();
        drive4(1'b1, 32'h22222222, 32'h104);
        tick();
        drive4(1'b0, 32'h0, 32'h0);
        #1;
        check("two_push_count", b4.count, 2);
        check("head_first", b4.out_instruction, 32'h11111111);
        b4.out_ready = 1'b1;
        tick();
        check("head_second", b4.out_instruction, 32'h22222222);
        tick();
        check("drained_out_valid", b4.out_valid, 0);
        check("drained_count", b4.count, 0);

        // 3: fill, reject when full, reopen after a pop, stream across wrap
        b4.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive4(1'b1, 32'hA0000000 + i, 32'h200 + 4 * i);
            tick();
        end
        drive4(1'b1, 32'hA5A5A5A5, 32'h210);
        #1;
        check("full_count", b4.count, 4);
        check("full_in_ready", b4.in_ready, 0);
        tick();
        check("full_reject_count", b4.count, 4);
        drive4(1'b0, 32'h0, 32'h0);
        b4.out_ready = 1'b1;
        tick();
        check("after_pop_in_ready", b4.in_ready, 1);
        check("after_pop_count", b4.count, 3);
        for (int i = 0; i < 10; i++) begin
            drive4(1'b1, 32'hB0000000 + i, 32'h300 + 4 * i);
            tick();
        end
        check("stream_count", b4.count, 3);
        drive4(1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 8 && b4.out_valid; k++) tick();
        check("stream_drained", b4.count, 0);

        // 4: DEPTH=3, push and pop every cycle
        b3.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b3.in_valid       = 1'b1;
            b3.in_instruction = 32'hC0000000 + i;
            b3.in_pc          = 32'h600 + 4 * i;
            tick();
            check("d3_stream_count", b3.count, BYP ? 0 : 1);
        end
        b3.in_valid = 1'b0;
        tick();
        check("d3_drained_count", b3.count, 0);
        check("d3_drained_valid", b3.out_valid, 0);
        b3.out_ready = 1'b0;

        // 5: flush with data and pop pending; first post-flush entry tagged
        b4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive4(1'b1, 32'hD0000000 + i, 32'h700 + 4 * i);
            tick();
        end
        drive4(1'b0, 32'h0, 32'h0);
        #1;
        check("preflush_count", b4.count, 3);
        b4.flush     = 1'b1;
        b4.out_ready = 1'b1;
        drive4(1'b1, 32'hDEADBEEF, 32'h2FC);
        #1;
        check("flush_in_ready", b4.in_ready, 0);
        tick();
        b4.flush     = 1'b0;
        b4.out_ready = 1'b0;
        drive4(1'b0, 32'h0, 32'h0);
        #1;
        check("postflush_count", b4.count, 0);
        check("postflush_out_valid", b4.out_valid, 0);
        drive4(1'b1, 32'hCAFEF00D, 32'h300);
        tick();
        drive4(1'b1, 32'h12345678, 32'h304);
        tick();
        drive4(1'b0, 32'h0, 32'h0);
        #1;
        check("flushed_head_tag", b4.out_has_flushed, 1);
        check("flushed_head_data", b4.out_instruction, 32'hCAFEF00D);
        b4.out_ready = 1'b1;
        tick();
        check("second_entry_tag", b4.out_has_flushed, 0);
        tick();
        check("flush_drained", b4.out_valid, 0);
        b4.out_ready = 1'b0;

        // 6: reset together with flush clears everything including the tag
        for (int i = 0; i < 2; i++) begin
            drive4(1'b1, 32'hE0000000 + i, 32'h800 + 4 * i);
            tick();
        end
        drive4(1'b0, 32'h0, 32'h0);
        #1;
        check("prereset_count", b4.count, 2);
        reset    = 1'b1;
        b4.flush = 1'b1;
        tick();
        reset    = 1'b0;
        b4.flush = 1'b0;
        #1;
        check("rstflush_count", b4.count, 0);
        check("rstflush_out_valid", b4.out_valid, 0);
        drive4(1'b1, 32'h55555555, 32'h400);
        tick();
        drive4(1'b0, 32'h0, 32'h0);
        #1;
        check("rstflush_valid", b4.out_valid, 1);
        check("rstflush_tag", b4.out_has_flushed, 0);
        b4.out_ready = 1'b1;
        tick();
        check("rstflush_drained", b4.count, 0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Bypass: empty queue passes the input straight through
        drive4(1'b1, 32'h77777777, 32'h500);
        #1;
        check("byp_out_valid", b4.out_valid, 1);
        check("byp_instruction", b4.out_instruction, 32'h77777777);
        check("byp_pc", b4.out_pc, 32'h500);
        check("byp_count_comb", b4.count, 0);
        tick();
        check("byp_count", b4.count, 0);
        drive4(1'b0, 32'h0, 32'h0);
        b4.flush = 1'b1;
        tick();
        b4.flush = 1'b0;
        drive4(1'b1, 32'h88888888, 32'h504);
        #1;
        check("byp_flushed_tag", b4.out_has_flushed, 1);
        tick();
        drive4(1'b1, 32'h99999999, 32'h508);
        #1;
        check("byp_tag_cleared", b4.out_has_flushed, 0);
        tick();
        drive4(1'b0, 32'h0, 32'h0);
        #1;
        check("byp_final_count", b4.count, 0);
`endif
        b4.out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
